// File: rtl/uart_tx_16x_if.sv
// Host-side bus of the 16x-oversampled UART transmitter.
//   master : host; drives tx_start / tx_data / tx_done_clr and reads the status.
//   slave  : transmitter; receives the request and drives TXD / tx_busy / tx_done_flag.
// Signals:
//   tx_start      request to send tx_data (sampled only while tx_busy=0)
//   tx_data[7:0]  byte to send, captured on the accepting edge
//   tx_done_clr   level clear of tx_done_flag
//   TXD           serial line, idle high
//   tx_busy       high from accept edge until the frame is fully sent
//   tx_done_flag  sticky frame-sent flag
interface uart_tx_16x_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done_clr;
  logic       TXD;
  logic       tx_busy;
  logic       tx_done_flag;

  modport master (
    output tx_start, tx_data, tx_done_clr,
    input  TXD, tx_busy, tx_done_flag
  );

  modport slave (
    input  tx_start, tx_data, tx_done_clr,
    output TXD, tx_busy, tx_done_flag
  );
endinterface

// File: rtl/uart_tx_16x.sv
// UART transmitter on the shared 16x-oversample clock.
// Frame: start(0), DATA_BITS data bits LSB first, optional parity, STOP_BITS stop(1).
// Each bit lasts OVERSAMPLE rx_clk cycles; TXD comes straight from a flop.
// Ports:
//   rx_clk   oversample clock, posedge
//   reset_n  asynchronous active-low reset
//   bus      uart_tx_16x_if.slave (tx_start, tx_data, tx_done_clr in;
//            TXD, tx_busy, tx_done_flag out)
module uart_tx_16x #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic          rx_clk,
  input  logic          reset_n,
  uart_tx_16x_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Sample counter is 5 bits so the stop phase (up to 2*16 cycles) runs as one span.
  localparam logic [4:0] LP_OS_LAST   = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] LP_STOP_LAST = 5'(STOP_BITS * OVERSAMPLE - 1);
  localparam logic [2:0] LP_BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [7:0] LP_DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic       LP_PAR_EN    = (PARITY_EN != 0);
  localparam logic       LP_PAR_ODD   = (PARITY_ODD != 0);

  logic [2:0] r_state;
  logic [4:0] r_sample;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic       r_parity;
  logic       r_txd;
  logic       r_busy;
  logic       r_done;

  logic w_bit_wrap;
  logic w_frame_end;
  logic w_parity_new;

  assign w_bit_wrap   = (r_sample == LP_OS_LAST);
  assign w_frame_end  = (r_state == S_STOP) && (r_sample == LP_STOP_LAST);
  // Parity is taken from the byte being latched, so later tx_data changes cannot affect it.
  assign w_parity_new = (^(bus.tx_data & LP_DATA_MASK)) ^ LP_PAR_ODD;

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_sample <= '0;
      r_bit    <= '0;
      r_shift  <= '1;
      r_parity <= 1'b0;
      r_txd    <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // Frame completion outranks a simultaneous clear.
      if (w_frame_end) begin
        r_done <= 1'b1;
      end else if (bus.tx_done_clr) begin
        r_done <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_txd    <= 1'b1;
          r_sample <= '0;
          r_bit    <= '0;
          if (bus.tx_start) begin
            r_shift  <= bus.tx_data;
            r_parity <= w_parity_new;
            r_busy   <= 1'b1;
            r_txd    <= 1'b0;
            r_state  <= S_START;
          end
        end

        S_START: begin
          if (w_bit_wrap) begin
            r_sample <= '0;
            r_bit    <= '0;
            r_txd    <= r_shift[0];
            r_state  <= S_DATA;
          end else begin
            r_sample <= r_sample + 5'd1;
          end
        end

        S_DATA: begin
          if (w_bit_wrap) begin
            r_sample <= '0;
            if (r_bit == LP_BIT_LAST) begin
              if (LP_PAR_EN) begin
                r_txd   <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_txd   <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              // Next data bit is shift[1]; shifting keeps the current bit at shift[0].
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b1, r_shift[7:1]};
              r_txd   <= r_shift[1];
            end
          end else begin
            r_sample <= r_sample + 5'd1;
          end
        end

        S_PARITY: begin
          if (w_bit_wrap) begin
            r_sample <= '0;
            r_txd    <= 1'b1;
            r_state  <= S_STOP;
          end else begin
            r_sample <= r_sample + 5'd1;
          end
        end

        S_STOP: begin
          r_txd <= 1'b1;
          if (r_sample == LP_STOP_LAST) begin
            r_sample <= '0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_sample <= r_sample + 5'd1;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_sample <= '0;
          r_bit    <= '0;
          r_txd    <= 1'b1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.TXD          = r_txd;
  assign bus.tx_busy      = r_busy;
  assign bus.tx_done_flag = r_done;

endmodule

// File: tb/tb_uart_tx_16x.sv
// Bench for uart_tx_16x: four parameterisations driven side by side, each
// checked every cycle against a frame-bit-list model, plus directed literal
// checks and a simple serial receiver on channel 0.
module tb_uart_tx_16x;
  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [NCH-1:0] start;
  logic [NCH-1:0] clr;
  logic [NCH-1:0] txd;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] done;
  logic [7:0]     data [NCH];

  int         checks = 0;
  int         errors = 0;
  logic       rx_en  = 1'b0;
  logic [7:0] rx_q [$];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy(input int c, input logic v, input string name);
    int n;
    n = 0;
    while (busy[c] !== v && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(busy[c]), 32'(v));
  endtask

  // Called at a negedge with channel c idle; returns at the negedge after the accept edge.
  task automatic pulse_start(input int c, input logic [7:0] d);
    data[c]  = d;
    start[c] = 1'b1;
    @(negedge clk);
    start[c] = 1'b0;
  endtask

  for (genvar g = 0; g < NCH; g++) begin : ch
    localparam int DB  = (g == 3) ? 5 : 8;
    localparam int OS  = (g == 3) ? 4 : 16;
    localparam int SB  = (g == 3) ? 2 : 1;
    localparam int PE  = (g == 0) ? 0 : 1;
    localparam int PO  = (g >= 2) ? 1 : 0;
    localparam int LEN = (1 + DB + PE + SB) * OS;

    uart_tx_16x_if bus ();
    assign bus.tx_start    = start[g];
    assign bus.tx_data     = data[g];
    assign bus.tx_done_clr = clr[g];
    assign txd[g]  = bus.TXD;
    assign busy[g] = bus.tx_busy;
    assign done[g] = bus.tx_done_flag;

    uart_tx_16x #(
      .DATA_BITS (DB),
      .OVERSAMPLE(OS),
      .STOP_BITS (SB),
      .PARITY_EN (PE),
      .PARITY_ODD(PO)
    ) dut (
      .rx_clk (clk),
      .reset_n(reset_n),
      .bus    (bus)
    );

    // Model: the frame is a list of line levels; cycle k of a frame shows bit k/OS.
    bit m_busy;
    bit m_done;
    int m_k;
    bit fb [16];

    initial begin
      logic [7:0] d;
      bit fin;
      bit par;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_k    = 0;
      for (int i = 0; i < 16; i++) fb[i] = 1'b1;
      forever begin
        @(posedge clk);
        if (!reset_n) begin
          m_busy = 1'b0;
          m_done = 1'b0;
          m_k    = 0;
        end else begin
          fin = 1'b0;
          if (m_busy) begin
            m_k++;
            if (m_k == LEN) begin
              m_busy = 1'b0;
              fin    = 1'b1;
            end
          end else if (start[g]) begin
            d   = data[g];
            par = (PO != 0);
            for (int i = 0; i < 16; i++) fb[i] = 1'b1;
            fb[0] = 1'b0;
            for (int i = 0; i < DB; i++) begin
              fb[1 + i] = d[i];
              par ^= d[i];
            end
            if (PE != 0) fb[1 + DB] = par;
            m_busy = 1'b1;
            m_k    = 0;
          end
          if (fin) m_done = 1'b1;
          else if (clr[g]) m_done = 1'b0;
        end
        #1;
        chk($sformatf("ch%0d TXD", g), 32'(txd[g]), m_busy ? 32'(fb[m_k / OS]) : 32'd1);
        chk($sformatf("ch%0d busy", g), 32'(busy[g]), 32'(m_busy));
        chk($sformatf("ch%0d done", g), 32'(done[g]), 32'(m_done));
      end
    end
  end

  // Receiver for channel 0 (8N1, 16x): find start, sample bit centres.
  initial begin
    logic [7:0] r;
    forever begin
      @(negedge clk);
      if (rx_en && txd[0] == 1'b0) begin
        tick(8);
        if (txd[0] == 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            tick(16);
            r[i] = txd[0];
          end
          tick(16);
          chk("rx stop bit", 32'(txd[0]), 32'd1);
          rx_q.push_back(r);
        end
      end
    end
  end

  initial begin
    int off;
    logic [7:0] b4 [4];
    b4[0] = 8'h00; b4[1] = 8'hFF; b4[2] = 8'hA5; b4[3] = 8'h5A;

    reset_n = 1'b0;
    start   = '0;
    clr     = '0;
    for (int i = 0; i < NCH; i++) data[i] = 8'h00;
    tick(3);
    chk("reset TXD", 32'(txd), 32'hF);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    reset_n = 1'b1;
    tick(2);

    // T1: 0x55 -> 0,1,0,1,... each 16 cycles; busy for 160 cycles
    pulse_start(0, 8'h55);
    off = 0;
    for (int j = 0; j < 10; j++) begin
      tick(16 * j + 8 - off);
      off = 16 * j + 8;
      chk($sformatf("T1 bit%0d", j), 32'(txd[0]), 32'(j % 2));
    end
    tick(159 - off);
    chk("T1 busy@159", 32'(busy[0]), 32'd1);
    chk("T1 done@159", 32'(done[0]), 32'd0);
    tick(1);
    chk("T1 busy@160", 32'(busy[0]), 32'd0);
    chk("T1 done@160", 32'(done[0]), 32'd1);

    // T4: clear held across frame end
    pulse_start(0, 8'hC3);
    tick(100);
    clr[0] = 1'b1;
    tick(2);
    chk("T4 done cleared mid-frame", 32'(done[0]), 32'd0);
    tick(58);
    chk("T4 set wins", 32'(done[0]), 32'd1);
    tick(1);
    chk("T4 cleared next", 32'(done[0]), 32'd0);
    clr[0] = 1'b0;

    // T2: second request mid-frame is ignored
    tick(2);
    pulse_start(0, 8'hA5);
    tick(24);
    chk("T2 data bit0", 32'(txd[0]), 32'd1);
    tick(15);
    data[0]  = 8'h00;
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    tick(64);
    chk("T2 data bit5", 32'(txd[0]), 32'd1);
    tick(56);
    chk("T2 frame end", 32'(busy[0]), 32'd0);
    chk("T2 done", 32'(done[0]), 32'd1);
    tick(2);
    chk("T2 no second frame", 32'(busy[0]), 32'd0);

    // T3: parity channels, 0x07
    data[1]  = 8'h07;
    data[2]  = 8'h07;
    start[1] = 1'b1;
    start[2] = 1'b1;
    tick(1);
    start[1] = 1'b0;
    start[2] = 1'b0;
    tick(152);
    chk("T3 even parity", 32'(txd[1]), 32'd1);
    chk("T3 odd parity", 32'(txd[2]), 32'd0);
    tick(23);
    chk("T3 busy@175", 32'(busy[1]), 32'd1);
    tick(1);
    chk("T3 busy@176 even", 32'(busy[1]), 32'd0);
    chk("T3 busy@176 odd", 32'(busy[2]), 32'd0);

    // T5: reset mid-frame
    pulse_start(0, 8'hFF);
    tick(70);
    reset_n = 1'b0;
    #1;
    chk("T5 TXD on reset", 32'(txd[0]), 32'd1);
    chk("T5 busy on reset", 32'(busy[0]), 32'd0);
    chk("T5 done on reset", 32'(done[0]), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    pulse_start(0, 8'h3C);
    wait_busy(0, 1'b0, "T5 0x3C frame completes");
    chk("T5 done after 0x3C", 32'(done[0]), 32'd1);

    // T6: back-to-back into the receiver
    rx_q.delete();
    rx_en = 1'b1;
    tick(2);
    data[0]  = b4[0];
    start[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) wait_busy(0, 1'b0, "T6 frame end");
      wait_busy(0, 1'b1, "T6 frame accept");
      if (i < 3) data[0] = b4[i + 1];
      else start[0] = 1'b0;
    end
    wait_busy(0, 1'b0, "T6 last frame end");
    tick(4);
    rx_en = 1'b0;
    chk("T6 rx count", 32'(rx_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("T6 rx byte%0d", i), (i < rx_q.size()) ? 32'(rx_q[i]) : 32'h100, 32'(b4[i]));

    // Random traffic on all channels, model-checked every cycle
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        start[c] = ($urandom_range(0, 9) == 0);
        data[c]  = 8'($urandom);
        clr[c]   = ($urandom_range(0, 19) == 0);
      end
      if (cyc == 2000) reset_n = 1'b0;
      if (cyc == 2003) reset_n = 1'b1;
      tick(1);
    end
    start = '0;
    clr   = '0;
    tick(200);
    chk("final idle", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
